// File: rtl/frame_buffer_ctrl.sv
// Single-clock frame buffer: stores one raster frame in simple-dual-port BRAM and replays it with an SOF tag.
// Optional colour-bar test pattern on the output is enabled by defining FBUF_TESTPAT_EN.
module frame_buffer_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int H_ACTIVE   = 320,
  parameter int V_ACTIVE   = 240
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_freeze,
`ifdef FBUF_TESTPAT_EN
  input  logic                  i_testpat,
`endif
  output logic                  o_rd,
  input  logic [DATA_WIDTH:0]   i_data,
  input  logic                  i_empty,
  output logic                  o_wr,
  output logic [DATA_WIDTH:0]   o_data,
  input  logic                  i_full,
  output logic                  o_frame_valid,
  output logic                  o_wr_done,
  output logic                  o_rd_done
);

  localparam int DEPTH      = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {W_SYNC, W_FILL, W_HOLD} wr_state_e;

  // Write side
  wr_state_e             state_q, state_d;
  logic                  pop_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  wr_done_q, wr_done_d;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic                  in_sof;
  logic [DATA_WIDTH-1:0] in_pix;
  logic                  resync;

  // Read side
  logic                  rd_issue;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  wr_q, wr_d;
  logic                  sof_q, sof_d;
  logic                  pix_ok_q, pix_ok_d;
  logic                  rd_done_q, rd_done_d;
  logic [DATA_WIDTH-1:0] mem_rdata_q;
  logic [DATA_WIDTH-1:0] pixel_out;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // The input FIFO is drained whenever it has data so capture never stalls; held off only in reset.
  assign o_rd   = i_rstn & ~i_empty;
  assign in_sof = i_data[DATA_WIDTH];
  assign in_pix = i_data[DATA_WIDTH-1:0];

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    frame_valid_d = frame_valid_q;
    wr_done_d     = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = wr_addr_q;
    // An SOF word restarts the frame at address 0 unless the frame is still frozen.
    resync        = pop_q && in_sof && ((state_q != W_HOLD) || !i_freeze);

    if (resync) begin
      mem_we    = 1'b1;
      mem_waddr = '0;
      wr_addr_d = ADDR_ONE;
      state_d   = W_FILL;
    end else begin
      unique case (state_q)
        W_FILL: begin
          if (pop_q) begin
            mem_we = 1'b1;
            if (wr_addr_q == LAST_ADDR) begin
              wr_done_d     = 1'b1;
              frame_valid_d = 1'b1;
              wr_addr_d     = '0;
              state_d       = i_freeze ? W_HOLD : W_SYNC;
            end else begin
              wr_addr_d = wr_addr_q + ADDR_ONE;
            end
          end
        end
        W_HOLD: begin
          if (!i_freeze) state_d = W_SYNC;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    // wr_q doubles as the read-pending flag: one output write in flight at most.
    rd_issue  = !i_full && !wr_q;
    wr_d      = rd_issue;
    rd_addr_d = rd_addr_q;
    sof_d     = sof_q;
    pix_ok_d  = pix_ok_q;
    rd_done_d = 1'b0;
    if (rd_issue) begin
      rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_ONE;
      sof_d     = (rd_addr_q == '0);
      pix_ok_d  = frame_valid_q;
      rd_done_d = (rd_addr_q == LAST_ADDR);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      // NOTE: sequential state always uses non-blocking assignments.
      state_q       <= W_SYNC;
      pop_q         <= 1'b0;
      wr_addr_q     <= '0;
      frame_valid_q <= 1'b0;
      wr_done_q     <= 1'b0;
      rd_addr_q     <= '0;
      wr_q          <= 1'b0;
      sof_q         <= 1'b0;
      pix_ok_q      <= 1'b0;
      rd_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pop_q         <= o_rd;
      wr_addr_q     <= wr_addr_d;
      frame_valid_q <= frame_valid_d;
      wr_done_q     <= wr_done_d;
      rd_addr_q     <= rd_addr_d;
      wr_q          <= wr_d;
      sof_q         <= sof_d;
      pix_ok_q      <= pix_ok_d;
      rd_done_q     <= rd_done_d;
    end
  end

  // NOTE: the BRAM and its output register carry no reset so they map onto block RAM; pix_ok_q masks stale data.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_waddr] <= in_pix;
    if (rd_issue) mem_rdata_q <= mem[rd_addr_q];
  end

`ifdef FBUF_TESTPAT_EN
  localparam int H_WIDTH = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int CW      = DATA_WIDTH / 3;
  localparam logic [H_WIDTH-1:0] H_LAST = H_WIDTH'(H_ACTIVE - 1);

  logic [H_WIDTH-1:0]    h_cnt_q, h_cnt_d;
  logic                  tp_q, tp_d;
  logic [DATA_WIDTH-1:0] tp_pix_q, tp_pix_d;
  logic [2:0]            bar;

  // Bars in order white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [DATA_WIDTH-1:0] bar_colour(input logic [2:0] idx);
    logic [DATA_WIDTH-1:0] px;
    px = '0;
    px[DATA_WIDTH-1 -: CW]        = {CW{~idx[1]}};
    px[DATA_WIDTH-1-CW -: CW]     = {CW{~idx[2]}};
    px[DATA_WIDTH-1-2*CW -: CW]   = {CW{~idx[0]}};
    return px;
  endfunction

  always_comb begin
    bar      = 3'((32'(h_cnt_q) * 32'd8) / 32'(H_ACTIVE));
    h_cnt_d  = h_cnt_q;
    tp_d     = tp_q;
    tp_pix_d = tp_pix_q;
    if (rd_issue) begin
      h_cnt_d  = (rd_addr_q == LAST_ADDR || h_cnt_q == H_LAST) ? '0 : h_cnt_q + H_WIDTH'(1);
      tp_d     = i_testpat;
      tp_pix_d = bar_colour(bar);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      h_cnt_q  <= '0;
      tp_q     <= 1'b0;
      tp_pix_q <= '0;
    end else begin
      h_cnt_q  <= h_cnt_d;
      tp_q     <= tp_d;
      tp_pix_q <= tp_pix_d;
    end
  end

  assign pixel_out = tp_q ? tp_pix_q : (pix_ok_q ? mem_rdata_q : '0);
`else
  assign pixel_out = pix_ok_q ? mem_rdata_q : '0;
`endif

  assign o_wr          = wr_q;
  assign o_data        = {sof_q, pixel_out};
  assign o_frame_valid = frame_valid_q;
  assign o_wr_done     = wr_done_q;
  assign o_rd_done     = rd_done_q;

endmodule
